// File: rtl/photon_beacon_array.sv
// photon_beacon_array: switching-load tile array with soft-start ramp, per-tile XOR signatures and status LEDs
module photon_beacon_array #(
  parameter int TILE_COUNT  = 4,
  parameter int FF_PER_TILE = 8192,
  parameter int BLINK_DIV_W = 27,
  parameter int RAMP_DIV_W  = 16,
  parameter int BURST_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TILE_COUNT-1:0] tile_en_sw,
  input  logic [1:0]            mode,
  output logic [TILE_COUNT-1:0] led_status,
  output logic [TILE_COUNT-1:0] tile_sig,
  output logic                  ramp_busy
);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state_q, state_d;
  logic [TILE_COUNT-1:0] sw_m_q, sw_s_q, active_q, active_d, pending, pending_d, first_pending;
  logic [TILE_COUNT-1:0] led_q, led_d, sig_q, tile_par;
  logic [1:0] mode_m_q, mode_s_q;
  logic [RAMP_DIV_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [BLINK_DIV_W-1:0] blink_cnt_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic ramp_fire;
  always_comb begin
    pending = sw_s_q & ~active_q;
    first_pending = pending & (~pending + TILE_COUNT'(1));
    ramp_fire = state_q == RAMP && ramp_cnt_q == '1;
    active_d = (active_q & sw_s_q) | (ramp_fire ? first_pending : '0);
    ramp_cnt_d = state_q == RAMP ? ramp_cnt_q + RAMP_DIV_W'(1) : '0;
    pending_d = sw_m_q & ~active_d;
    state_d = |pending_d ? RAMP : IDLE;
    led_d = sw_s_q & (pending | ({TILE_COUNT{blink_cnt_q[BLINK_DIV_W-1]}} & active_q));
  end
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    ramp_busy = state_q == RAMP;
    led_status = led_q;
    tile_sig = sig_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sw_m_q <= '0;
      sw_s_q <= '0;
      mode_m_q <= '0;
      mode_s_q <= '0;
      active_q <= '0;
      ramp_cnt_q <= '0;
      blink_cnt_q <= '0;
      burst_cnt_q <= '0;
      sig_q <= '0;
      led_q <= '0;
    end else begin
      sw_m_q <= tile_en_sw;
      sw_s_q <= sw_m_q;
      mode_m_q <= mode;
      mode_s_q <= mode_m_q;
      active_q <= active_d;
      ramp_cnt_q <= ramp_cnt_d;
      blink_cnt_q <= blink_cnt_q + BLINK_DIV_W'(1);
      burst_cnt_q <= burst_cnt_q + BURST_W'(1);
      sig_q <= tile_par;
      led_q <= led_d;
    end
  for (genvar t = 0; t < TILE_COUNT; t++) begin : g_tile
    logic [FF_PER_TILE-1:0] bits_q, bits_d;
    logic [31:0] lfsr_q, lfsr_d;
    always_comb begin
      bits_d = !active_q[t] ? '0 :
               mode_s_q == 2'd0 ? ~bits_q :
               mode_s_q == 2'd1 ? {bits_q[FF_PER_TILE-2:0], lfsr_q[31]} :
               mode_s_q == 2'd3 && burst_cnt_q[BURST_W-1] ? ~bits_q : bits_q;
      lfsr_d = active_q[t] && mode_s_q == 2'd1 ?
               {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? 32'h0040_0007 : 32'h0) : lfsr_q;
    end
    always_ff @(posedge clk)
      if (rst) begin
        bits_q <= '0;
        lfsr_q <= 32'hACE1_0000 | 32'(t + 1);
      end else begin
        bits_q <= bits_d;
        lfsr_q <= lfsr_d;
      end
    assign tile_par[t] = ^bits_q;
  end
endmodule

// File: tb/tb_photon_beacon_array.sv
// tb_photon_beacon_array: randomized scoreboard bench against a behavioural tile-array model
module tb_photon_beacon_array;
  localparam int TC = 4;
  localparam int FF = 9;
  localparam int RAMP_LEN = 1 << 3;
  localparam int BLINK_MOD = 1 << 4;
  localparam int BURST_MOD = 1 << 2;
  logic clk = 0;
  logic rst = 1;
  logic [TC-1:0] tile_en_sw = '0;
  logic [1:0] mode = '0;
  logic [TC-1:0] led_status, tile_sig;
  logic ramp_busy;
  int tests = 0;
  int fails = 0;
  typedef struct packed {logic [TC-1:0] led; logic [TC-1:0] sig; logic busy;} exp_t;
  exp_t exp_q[$];
  logic [TC-1:0] m_sw1, m_sw2, m_act, m_led, m_sig;
  logic [1:0] m_mode1, m_mode2;
  logic [FF-1:0] m_bits [TC];
  logic [31:0] m_lfsr [TC];
  int m_wait, m_blink, m_burst;
  logic busy_at [1:40];

  photon_beacon_array #(.TILE_COUNT(TC), .FF_PER_TILE(FF), .BLINK_DIV_W(4), .RAMP_DIV_W(3), .BURST_W(2)) dut (
    .clk(clk), .rst(rst), .tile_en_sw(tile_en_sw), .mode(mode),
    .led_status(led_status), .tile_sig(tile_sig), .ramp_busy(ramp_busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] poly;
    poly = '0;
    poly[22] = 1'b1;
    poly[2] = 1'b1;
    poly[1] = 1'b1;
    poly[0] = 1'b1;
    return (s << 1) ^ (s[31] ? poly : 32'h0);
  endfunction

  task automatic model_step();
    logic [TC-1:0] pend, nact, nled, nsig;
    bit found;
    if (rst) begin
      m_sw1 = '0; m_sw2 = '0; m_act = '0; m_led = '0; m_sig = '0;
      m_mode1 = '0; m_mode2 = '0; m_wait = 0; m_blink = 0; m_burst = 0;
      for (int i = 0; i < TC; i++) begin
        m_bits[i] = '0;
        m_lfsr[i] = 32'hACE1_0000 | (i + 1);
      end
    end else begin
      pend = m_sw2 & ~m_act;
      for (int i = 0; i < TC; i++) begin
        nled[i] = !m_sw2[i] ? 1'b0 : pend[i] ? 1'b1 : (m_blink >= BLINK_MOD / 2);
        nsig[i] = ^m_bits[i];
        if (!m_act[i]) m_bits[i] = '0;
        else if (m_mode2 == 0) m_bits[i] = ~m_bits[i];
        else if (m_mode2 == 1) begin
          m_bits[i] = {m_bits[i][FF-2:0], m_lfsr[i][31]};
          m_lfsr[i] = lfsr_next(m_lfsr[i]);
        end else if (m_mode2 == 3 && m_burst >= BURST_MOD / 2) m_bits[i] = ~m_bits[i];
      end
      nact = m_act & m_sw2;
      if (pend != 0) begin
        m_wait++;
        if (m_wait == RAMP_LEN) begin
          m_wait = 0;
          found = 0;
          for (int i = 0; i < TC; i++)
            if (pend[i] && !found) begin
              nact[i] = 1'b1;
              found = 1;
            end
        end
      end else m_wait = 0;
      m_blink = (m_blink + 1) % BLINK_MOD;
      m_burst = (m_burst + 1) % BURST_MOD;
      m_act = nact; m_led = nled; m_sig = nsig;
      m_sw2 = m_sw1; m_sw1 = tile_en_sw;
      m_mode2 = m_mode1; m_mode1 = mode;
    end
    exp_q.push_back('{led: m_led, sig: m_sig, busy: |(m_sw2 & ~m_act)});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("led_status", 32'(led_status), 32'(e.led));
      check("tile_sig", 32'(tile_sig), 32'(e.sig));
      check("ramp_busy", 32'(ramp_busy), 32'(e.busy));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(3);
    rst = 0;
    step(5);
    tile_en_sw = 4'b1111;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      busy_at[k] = ramp_busy;
    end
    check("busy_edge1", 32'(busy_at[1]), 0);
    check("busy_edge2", 32'(busy_at[2]), 1);
    check("busy_edge33", 32'(busy_at[33]), 1);
    check("busy_edge34", 32'(busy_at[34]), 0);
    step(30);
    mode = 2'd3; step(20);
    mode = 2'd2; step(10);
    mode = 2'd1; step(50);
    mode = 2'd0; step(10);
    tile_en_sw = 4'b1110; step(15);
    tile_en_sw = 4'b1111; step(20);
    rst = 1; step(2); rst = 0;
    tile_en_sw = 4'b1111; step(11);
    tile_en_sw = 4'b1101; step(40);
    rst = 1; step(2); rst = 0;
    tile_en_sw = 4'b1111; step(13);
    rst = 1; step(1);
    check("midramp_busy", 32'(ramp_busy), 0);
    check("midramp_led", 32'(led_status), 0);
    check("midramp_sig", 32'(tile_sig), 0);
    rst = 0; step(45);
    for (int n = 0; n < 40; n++) begin
      tile_en_sw = 4'($urandom);
      mode = 2'($urandom);
      repeat ($urandom_range(1, 30)) begin
        rst = ($urandom_range(0, 149) == 0);
        step(1);
      end
    end
    rst = 0;
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/photon_beacon_array.md
Name: photon_beacon_array

Overview:
- Parametrised successor to the fixed four-tile photon beacon core.
- Holds TILE_COUNT tiles of FF_PER_TILE flip-flops. Each tile, when enabled, is driven in one of four activity modes, giving a controlled switching load for emission and power experiments.
- Adds a soft-start ramp so tiles come up one at a time, limiting supply di/dt. Also adds per-tile XOR signatures so synthesis cannot prune the tiles.
- Sits directly under the board top. It takes the slide switches and mode inputs and drives the user LEDs.

Parameters:
- TILE_COUNT, 4, number of tiles. Range 1..16.
- FF_PER_TILE, 8192, flip-flops per tile. Must be >= 2.
- BLINK_DIV_W, 27, width of the free-running LED blink counter.
- RAMP_DIV_W, 16, soft-start spacing: 2^RAMP_DIV_W cycles between successive tile activations.
- BURST_W, 8, burst counter width for mode 3.

Ports:
- clk  in  1  fabric clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tile_en_sw  in  TILE_COUNT  per-tile enable request; asynchronous (switches).
- mode  in  2  activity mode; asynchronous; 0 toggle, 1 LFSR, 2 hold, 3 burst.
- led_status  out  TILE_COUNT  per-tile status LED.
- tile_sig  out  TILE_COUNT  registered XOR-reduction of each tile's flip-flops.
- ramp_busy  out  1  high while any requested tile is still waiting in the ramp.

Behaviour:
- Reset: all state is cleared on the clk edge with rst high: synchronisers, active mask, ramp counter, blink counter, burst counter, tile flip-flops, tile_sig, led_status, ramp_busy.
- Reset LFSR seed for tile i: 32'hACE1_0000 | (i+1).
- rst has priority over every other event, including mid-ramp and mid-burst.
- Synchronisation: tile_en_sw and mode each pass through a 2-flop synchroniser (sw_s, mode_s), so both take effect 2 edges after the input changes.
- pending = sw_s & ~active.
- ramp_busy = |pending, combinational from registers.
- Ramp FSM, IDLE (pending==0) and RAMP (pending!=0):
  - IDLE: ramp_cnt is held at 0.
  - RAMP: ramp_cnt increments each edge. When ramp_cnt == 2^RAMP_DIV_W-1, set the lowest-index pending bit in active, clear ramp_cnt, and stay in RAMP if further bits remain pending.
  - Only one tile activates per ramp interval.
- Deactivation is immediate: active <= active & sw_s on every edge, ahead of any ramp set.
  - If a tile's request drops while it is pending, it leaves pending with no activation.
  - If pending empties, the FSM returns to IDLE and ramp_cnt clears.
- Tile update, each edge:
  - If !active[i], tile bits <= 0.
  - Otherwise by mode_s:
    - 0: bits <= ~bits.
    - 1: bits <= {bits[FF_PER_TILE-2:0], lfsr_i[31]}. lfsr_i is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, that advances only while the tile is active in mode 1.
    - 2: bits hold.
    - 3: bits <= ~bits only when burst_cnt[BURST_W-1]==1, otherwise hold. burst_cnt is free-running.
- A mode change takes effect on the edge after mode_s updates. Tile bits and LFSR state are never cleared by a mode change.
- tile_sig[i] <= ^bits_i, one edge after the bits update.
- led_status[i], registered:
  - 0 when !sw_s[i].
  - 1 (solid) when pending[i].
  - blink_cnt[BLINK_DIV_W-1] when active[i].
- blink_cnt is free-running and wraps.
- Width rule: all counters wrap modulo 2^width with no saturation.

Test Plan (TILE_COUNT=4, FF_PER_TILE=9, BLINK_DIV_W=4, RAMP_DIV_W=3, BURST_W=2; edge 1 = first edge with the new input stable):
- Reset: hold rst for 3 edges, then release.
  - All outputs are 0.
  - tile_sig stays 0 with sw=0.
  - ramp_busy=0.
- Ramp: set tile_en_sw=4'b1111, mode=0.
  - ramp_busy rises after edge 2.
  - led_status=1111 (solid) until activations.
  - Tile 0 activates at edge 10, tile 1 at edge 18, tile 2 at edge 26, tile 3 at edge 34.
  - ramp_busy falls after edge 34.
- Toggle signature: tile 0 active in mode 0 with odd FF count.
  - tile_sig[0] alternates 1,0,1,... each cycle, starting one edge after the first toggle.
  - led_status[0] follows blink_cnt[3] (8 high, 8 low).
- Drop while pending: sw=1111, drop sw[1] at edge 12.
  - Tile 1 never activates.
  - Tile 2 activates 8 cycles after tile 0's activation.
  - led_status[1]=0 after the sync delay.
- Immediate off: clear sw[0] while tile 0 is active.
  - active[0] drops at edge 3.
  - Tile 0 bits are 0 at edge 4.
  - tile_sig[0]=0 at edge 5.
  - Other tiles are unaffected.
- Modes: active tile in mode 3.
  - Bits toggle only in the 2 of every 4 cycles where burst_cnt[1]=1.
- Modes: switch the active tile to mode 2.
  - tile_sig freezes.
- Modes: switch the active tile to mode 1.
  - Bits shift the LFSR MSB in.
  - The sequence matches the seed 32'hACE1_0001 reference model.
- Reset mid-ramp: assert rst during the second ramp interval.
  - active=0, ramp_cnt=0, ramp_busy=0 on that edge.
  - After release, the ramp restarts from tile 0.
